// File: rtl/dma_ep_pkg.sv
// dma_ep_pkg: shared states, direction codes and default widths for the DMA peripheral endpoint
package dma_ep_pkg;
    typedef enum logic [2:0] {IDLE, ARMED, REQ, XFER, TERM} state_e;
    localparam logic DMA_DIR_DEV2MEM = 1'b0;
    localparam logic DMA_DIR_MEM2DEV = 1'b1;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/dma_ep_fifo.sv
// dma_ep_fifo: synchronous FIFO; pointers carry an extra wrap bit so full and empty differ
module dma_ep_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W-1:0]            head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic do_push, do_pop;
    always_comb begin
        level = wr_q - rd_q;
        empty = level == '0;
        full = level == (AW+1)'(FIFO_DEPTH);
        head = mem_q[rd_q[AW-1:0]];
        do_pop = pop & ~empty;
        do_push = push & (~full | do_pop);
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/dma_peripheral_endpoint.sv
// dma_peripheral_endpoint: 8237A-style DMA peripheral responder with a local FIFO.
// DMA_EP_EOP_DRIVE_EN adds block_len / eop_drv_n for device-initiated termination.
module dma_peripheral_endpoint
    import dma_ep_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              enable,
    input  logic              mode_dir,
    output logic              DREQ,
    input  logic              DACK,
    input  logic              IOR_N,
    input  logic              IOW_N,
    input  logic              EOP_N,
    input  logic [DATA_W-1:0] DB_in,
    output logic [DATA_W-1:0] DB_out,
    output logic              DB_oe,
    input  logic              dev_wr_valid,
    input  logic [DATA_W-1:0] dev_wr_data,
    output logic              dev_wr_ready,
    output logic              dev_rd_valid,
    output logic [DATA_W-1:0] dev_rd_data,
    input  logic              dev_rd_ready,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              tc_done,
    output logic              overrun,
    output logic              underrun
`ifdef DMA_EP_EOP_DRIVE_EN
    ,
    input  logic [CNT_W-1:0]  block_len,
    output logic              eop_drv_n
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    state_e state_q, state_d;
    logic dir_q, dir_d, dreq_q, dreq_d, tc_q, tc_d, ovr_q, ovr_d, unr_q, unr_d;
    logic ior_q, iow_q, en_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] db_q, db_d, head, push_data;
    logic [AW:0] level, lvl_n;
    logic full, empty, dir, active, en_rise, rd_done, wr_done, done;
    logic push, pop, ext_eop, dev_eop, cond_now, cond_post;
`ifdef DMA_EP_EOP_DRIVE_EN
    logic [CNT_W-1:0] blen_q, blen_d;
    logic eop_q, eop_d;
    assign eop_drv_n = eop_q;
`endif

    dma_ep_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(CLK), .rst_n(RESET), .push(push), .pop(pop), .din(push_data),
        .head(head), .full(full), .empty(empty), .level(level)
    );

    always_comb begin
        dir = (state_q == IDLE) ? mode_dir : dir_q;
        active = (state_q == REQ) || (state_q == XFER);
        en_rise = enable & ~en_q;
        // a strobe completes on its rising edge, seen as registered-low then high
        rd_done = active & DACK & (dir_q == DMA_DIR_DEV2MEM) & ~ior_q & IOR_N;
        wr_done = active & DACK & (dir_q == DMA_DIR_MEM2DEV) & ~iow_q & IOW_N;
        done = rd_done | wr_done;
        dev_wr_ready = (dir == DMA_DIR_DEV2MEM) & ~full;
        dev_rd_valid = (dir == DMA_DIR_MEM2DEV) & ~empty;
        dev_rd_data = head;
        pop = (dir == DMA_DIR_DEV2MEM) ? rd_done & ~empty : dev_rd_valid & dev_rd_ready;
        push = (dir == DMA_DIR_DEV2MEM) ? dev_wr_valid & dev_wr_ready : wr_done & (~full | pop);
        push_data = (dir == DMA_DIR_DEV2MEM) ? dev_wr_data : db_q;
        db_d = IOW_N ? db_q : DB_in;
        lvl_n = level + (AW+1)'(push) - (AW+1)'(pop);
        cond_now = (dir_q == DMA_DIR_DEV2MEM) ? ~empty : ~full;
        cond_post = (dir_q == DMA_DIR_DEV2MEM) ? lvl_n != '0 : lvl_n != (AW+1)'(FIFO_DEPTH);
        DB_oe = active & DACK & (dir_q == DMA_DIR_DEV2MEM) & ~IOR_N;
        DB_out = (DB_oe & ~empty) ? head : '0;
        ext_eop = active & DACK & ~EOP_N;
`ifdef DMA_EP_EOP_DRIVE_EN
        blen_d = en_rise ? block_len : blen_q;
        dev_eop = done & (blen_q != '0) & (cnt_q + CNT_W'(1) == blen_q);
        eop_d = ~dev_eop;
`else
        dev_eop = 1'b0;
`endif
        unique case (state_q)
            IDLE:    state_d = ARMED;
            ARMED:   state_d = cond_now ? REQ : ARMED;
            REQ:     state_d = DACK ? XFER : REQ;
            XFER:    state_d = DACK ? XFER : ARMED;
            default: state_d = TERM;
        endcase
        state_d = !enable ? IDLE : (ext_eop | dev_eop) ? TERM : state_d;
        dir_d = (state_q == IDLE) ? mode_dir : dir_q;
        dreq_d = ((state_d == REQ) || (state_d == XFER)) & cond_post;
        tc_d = (state_d == TERM) & (state_q != TERM);
        cnt_d = en_rise ? '0 : cnt_q + CNT_W'(done);
        ovr_d = ovr_q | (wr_done & full & ~pop);
        unr_d = unr_q | (rd_done & empty);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            dir_q <= DMA_DIR_DEV2MEM;
            dreq_q <= 1'b0;
            tc_q <= 1'b0;
            ovr_q <= 1'b0;
            unr_q <= 1'b0;
            cnt_q <= '0;
            db_q <= '0;
            ior_q <= 1'b1;
            iow_q <= 1'b1;
            en_q <= 1'b0;
`ifdef DMA_EP_EOP_DRIVE_EN
            blen_q <= '0;
            eop_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            dir_q <= dir_d;
            dreq_q <= dreq_d;
            tc_q <= tc_d;
            ovr_q <= ovr_d;
            unr_q <= unr_d;
            cnt_q <= cnt_d;
            db_q <= db_d;
            ior_q <= IOR_N;
            iow_q <= IOW_N;
            en_q <= enable;
`ifdef DMA_EP_EOP_DRIVE_EN
            blen_q <= blen_d;
            eop_q <= eop_d;
`endif
        end
    end

    assign DREQ = dreq_q;
    assign tc_done = tc_q;
    assign overrun = ovr_q;
    assign underrun = unr_q;
    assign xfer_count = cnt_q;
endmodule

// File: tb/tb_dma_peripheral_endpoint.sv
// tb_dma_peripheral_endpoint: directed stimulus with a queue scoreboard for bus and local read data
module tb_dma_peripheral_endpoint;
    logic CLK = 0, RESET = 0, enable = 0, mode_dir = 0, DACK = 0, IOR_N = 1, IOW_N = 1, EOP_N = 1;
    logic [7:0] DB_in = 0, dev_wr_data = 0;
    logic dev_wr_valid = 0, dev_rd_ready = 0;
    logic DREQ, DB_oe, dev_wr_ready, dev_rd_valid, tc_done, overrun, underrun;
    logic [7:0] DB_out, dev_rd_data;
    logic [15:0] xfer_count;
`ifdef DMA_EP_EOP_DRIVE_EN
    logic [15:0] block_len = 0;
    logic eop_drv_n;
`endif
    int checks = 0, failures = 0;
    logic [7:0] exp_bus[$], exp_dev[$];
    logic oe_seen = 0;

    always #5 CLK = ~CLK;

    dma_peripheral_endpoint dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .mode_dir(mode_dir), .DREQ(DREQ), .DACK(DACK),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N), .DB_in(DB_in), .DB_out(DB_out), .DB_oe(DB_oe),
        .dev_wr_valid(dev_wr_valid), .dev_wr_data(dev_wr_data), .dev_wr_ready(dev_wr_ready),
        .dev_rd_valid(dev_rd_valid), .dev_rd_data(dev_rd_data), .dev_rd_ready(dev_rd_ready),
        .xfer_count(xfer_count), .tc_done(tc_done), .overrun(overrun), .underrun(underrun)
`ifdef DMA_EP_EOP_DRIVE_EN
        , .block_len(block_len), .eop_drv_n(eop_drv_n)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_dreq(input string name);
        int n = 0;
        while (!DREQ && n < 20) begin
            tick(1);
            n++;
        end
        chk(name, DREQ, 1);
    endtask

    task automatic dev_push(input logic [7:0] d);
        dev_wr_valid = 1;
        dev_wr_data = d;
        exp_bus.push_back(d);
        tick(1);
        dev_wr_valid = 0;
    endtask

    task automatic ior(input logic eop);
        IOR_N = 0;
        tick(1);
        IOR_N = 1;
        EOP_N = ~eop;
        tick(1);
        EOP_N = 1;
    endtask

    task automatic iow(input logic [7:0] d);
        DB_in = d;
        IOW_N = 0;
        tick(1);
        IOW_N = 1;
        tick(1);
    endtask

    // monitor: every bus read window and every local pop is scored against its queue
    always @(negedge CLK) begin
        if (RESET) begin
            if (DB_oe && !oe_seen) begin
                if (exp_bus.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bus_data unexpected: got %0h expected none", DB_out);
                end else chk("bus_data", DB_out, exp_bus.pop_front());
            end
            if (dev_rd_valid && dev_rd_ready) begin
                if (exp_dev.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dev_data unexpected: got %0h expected none", dev_rd_data);
                end else chk("dev_data", dev_rd_data, exp_dev.pop_front());
            end
        end
        oe_seen = DB_oe;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_dreq", DREQ, 0);
        chk("rst_db_oe", DB_oe, 0);
        chk("rst_db_out", DB_out, 0);
        chk("rst_count", xfer_count, 0);
        chk("rst_flags", {tc_done, overrun, underrun}, 0);
        chk("rst_wr_ready", dev_wr_ready, 1);
        tick(2);
        RESET = 1;
        tick(1);
        // mode 0: three bytes read out by the DMA
        dev_push(8'hA1);
        dev_push(8'hB2);
        dev_push(8'hC3);
        enable = 1;
        tick(1);
        wait_dreq("m0_dreq");
        DACK = 1;
        tick(1);
        ior(0);
        chk("m0_dreq_after1", DREQ, 1);
        ior(0);
        ior(0);
        chk("m0_dreq_after3", DREQ, 0);
        chk("m0_count", xfer_count, 3);
        chk("m0_underrun", underrun, 0);
        DACK = 0;
        tick(1);
        // EOP on the second of four strobes
        dev_push(8'hD0);
        dev_push(8'hD1);
        dev_push(8'hD2);
        dev_push(8'hD3);
        wait_dreq("eop_dreq");
        DACK = 1;
        tick(1);
        ior(0);
        ior(1);
        chk("eop_tc", tc_done, 1);
        chk("eop_dreq", DREQ, 0);
        chk("eop_count", xfer_count, 5);
        tick(1);
        chk("eop_tc_pulse", tc_done, 0);
        DACK = 0;
        ior(0);
        tick(3);
        chk("term_no_req", DREQ, 0);
        chk("term_count", xfer_count, 5);
        enable = 0;
        tick(1);
        enable = 1;
        tick(1);
        chk("rearm_count", xfer_count, 0);
        wait_dreq("rearm_dreq");
        // level 4 with a push and a bus pop in the same cycle
        dev_push(8'hE0);
        dev_push(8'hE1);
        DACK = 1;
        tick(1);
        IOR_N = 0;
        tick(1);
        IOR_N = 1;
        dev_wr_valid = 1;
        dev_wr_data = 8'hE2;
        exp_bus.push_back(8'hE2);
        tick(1);
        dev_wr_valid = 0;
        ior(0);
        ior(0);
        ior(0);
        chk("lvl_dreq_1left", DREQ, 1);
        ior(0);
        chk("lvl_dreq_empty", DREQ, 0);
        chk("lvl_count", xfer_count, 5);
        // read strobe with nothing buffered
        exp_bus.push_back(8'h00);
        ior(0);
        chk("under_flag", underrun, 1);
        chk("under_count", xfer_count, 6);
        DACK = 0;
        tick(1);
        // mode 1: DMA fills the FIFO, then overruns it
        enable = 0;
        tick(1);
        mode_dir = 1;
        enable = 1;
        tick(1);
        chk("m1_wr_ready", dev_wr_ready, 0);
        wait_dreq("m1_dreq");
        DACK = 1;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            iow(8'(i));
            exp_dev.push_back(8'(i));
            if (i == 14) chk("m1_dreq_15", DREQ, 1);
        end
        chk("m1_dreq_full", DREQ, 0);
        iow(8'hFF);
        chk("m1_overrun", overrun, 1);
        chk("m1_count", xfer_count, 17);
        DACK = 0;
        tick(1);
        dev_rd_ready = 1;
        tick(16);
        dev_rd_ready = 0;
        chk("m1_drained", dev_rd_valid, 0);
        // asynchronous reset in the middle of a transfer
        wait_dreq("rst_mid_dreq");
        DACK = 1;
        tick(1);
        for (int i = 0; i < 5; i++) iow(8'(8'h50 + i));
        chk("pre_rst_dreq", DREQ, 1);
        chk("pre_rst_flags", {overrun, underrun}, 2'b11);
        #3;
        RESET = 0;
        #1;
        chk("mid_rst_dreq", DREQ, 0);
        chk("mid_rst_db_oe", DB_oe, 0);
        chk("mid_rst_empty", dev_rd_valid, 0);
        chk("mid_rst_flags", {tc_done, overrun, underrun}, 0);
        chk("mid_rst_count", xfer_count, 0);
        DACK = 0;
        enable = 0;
        mode_dir = 0;
        @(posedge CLK);
        #1;
        RESET = 1;
        tick(1);
`ifdef DMA_EP_EOP_DRIVE_EN
        block_len = 3;
        dev_push(8'h31);
        dev_push(8'h32);
        dev_push(8'h33);
        dev_push(8'h34);
        void'(exp_bus.pop_back());
        enable = 1;
        tick(1);
        wait_dreq("blk_dreq");
        DACK = 1;
        tick(1);
        ior(0);
        ior(0);
        chk("blk_eop_idle", eop_drv_n, 1);
        ior(0);
        chk("blk_eop_drv", eop_drv_n, 0);
        chk("blk_tc", tc_done, 1);
        chk("blk_dreq", DREQ, 0);
        tick(1);
        chk("blk_eop_release", eop_drv_n, 1);
        DACK = 0;
        enable = 0;
        tick(1);
`endif
        chk("bus_queue_left", exp_bus.size(), 0);
        chk("dev_queue_left", exp_dev.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
